// File: rtl/seg_pkg.sv
// Shared constants for the 4-digit multiplexed seven-segment scanner:
// segment codes (active-low, {g,f,e,d,c,b,a}), anode patterns (active-low),
// scan slot encoding and the default refresh divider.
package seg_pkg;

    // 50 MHz / 50000 = 1 kHz digit slot rate
    localparam int REFRESH_DIV_DEFAULT = 50000;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Digit code that the decoder always renders as blank
    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    // Active-low anode patterns
    localparam logic [3:0] AN_OFF   = 4'b1111;
    localparam logic [3:0] AN_SLOT0 = 4'b1110;
    localparam logic [3:0] AN_SLOT1 = 4'b1101;
    localparam logic [3:0] AN_SLOT2 = 4'b1011;
    localparam logic [3:0] AN_SLOT3 = 4'b0111;

    // Scan slots, in scan order
    typedef enum logic [1:0] {
        SLOT_VAL_ONES  = 2'd0,
        SLOT_VAL_TENS  = 2'd1,
        SLOT_WRAP_ONES = 2'd2,
        SLOT_WRAP_TENS = 2'd3
    } slot_e;

    function automatic logic [3:0] anode_for(input slot_e slot);
        logic [3:0] pattern;
        case (slot)
            SLOT_VAL_ONES:  pattern = AN_SLOT0;
            SLOT_VAL_TENS:  pattern = AN_SLOT1;
            SLOT_WRAP_ONES: pattern = AN_SLOT2;
            SLOT_WRAP_TENS: pattern = AN_SLOT3;
            default:        pattern = AN_OFF;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational digit-to-segment decoder. Digits 0..9 map to their glyphs;
// anything else (including DIGIT_BLANK) produces an all-off code.
module seg7_decoder
    import seg_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    // Table lookup with blank as the fallback for out-of-range digits
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver.
// Digits 0/1 show the upstream value in decimal (tens blanked when zero),
// digits 2/3 show a 2-digit BCD count of finish rising edges.
// All four digits of a frame come from one snapshot taken on the 3->0 tick.
//
// slot | meaning
// 0    | value ones,  an=1110
// 1    | value tens,  an=1101 (blank when 0)
// 2    | wrap ones,   an=1011, decimal point lit as separator
// 3    | wrap tens,   an=0111
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] value,
    input  logic       finish,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int               PW         = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] r_presc;
    slot_e         r_slot;
    logic          r_fin_d;
    logic [3:0]    r_wc_ones;
    logic [3:0]    r_wc_tens;
    logic [3:0]    r_snap_val;
    logic [3:0]    r_snap_wc_ones;
    logic [3:0]    r_snap_wc_tens;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          w_tick;
    slot_e         w_slot_next;
    logic          w_frame_start;
    logic          w_fin_rise;
    logic [3:0]    w_src_val;
    logic [3:0]    w_src_wc_ones;
    logic [3:0]    w_src_wc_tens;
    logic          w_val_tens;
    logic [3:0]    w_val_ones;
    logic [3:0]    w_digit;
    logic [6:0]    w_seg_code;

    assign w_tick        = (r_presc == PRESC_LAST);
    assign w_slot_next   = slot_e'(r_slot + 2'd1);
    assign w_frame_start = w_tick && (r_slot == SLOT_WRAP_TENS);
    assign w_fin_rise    = finish && !r_fin_d;

    // On the frame-start tick the snapshot is being loaded this same edge, so
    // the slot-0 digit must come from the live inputs rather than the old copy.
    // The live wrap count excludes a finish edge in this cycle, which therefore
    // lands in the next frame.
    assign w_src_val     = w_frame_start ? value     : r_snap_val;
    assign w_src_wc_ones = w_frame_start ? r_wc_ones : r_snap_wc_ones;
    assign w_src_wc_tens = w_frame_start ? r_wc_tens : r_snap_wc_tens;

    // Binary 0..15 to decimal: tens is 0 or 1
    assign w_val_tens = (w_src_val >= 4'd10);
    assign w_val_ones = w_val_tens ? (w_src_val - 4'd10) : w_src_val;

    // Pick the digit for the slot about to be driven
    always_comb begin
        w_digit = DIGIT_BLANK;
        case (w_slot_next)
            SLOT_VAL_ONES:  w_digit = w_val_ones;
            SLOT_VAL_TENS:  w_digit = w_val_tens ? 4'd1 : DIGIT_BLANK;
            SLOT_WRAP_ONES: w_digit = w_src_wc_ones;
            SLOT_WRAP_TENS: w_digit = w_src_wc_tens;
            default:        w_digit = DIGIT_BLANK;
        endcase
    end

    seg7_decoder u_seg7_decoder (
        .i_digit (w_digit),
        .o_seg   (w_seg_code)
    );

    // Slot-rate prescaler, 0..REFRESH_DIV-1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Scan slot sequencer with registered digit outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot <= SLOT_VAL_ONES;
            r_an   <= AN_OFF;
            r_seg  <= SEG_BLANK;
            r_dp   <= 1'b1;
        end else if (w_tick) begin
            r_slot <= w_slot_next;
            r_an   <= anode_for(w_slot_next);
            r_seg  <= w_seg_code;
            r_dp   <= (w_slot_next != SLOT_WRAP_ONES);
        end
    end

    // Finish edge detect and 2-digit BCD wrap counter, 00..99 rolling over
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fin_d   <= 1'b0;
            r_wc_ones <= 4'd0;
            r_wc_tens <= 4'd0;
        end else begin
            r_fin_d <= finish;
            if (w_fin_rise) begin
                if (r_wc_ones == 4'd9) begin
                    r_wc_ones <= 4'd0;
                    r_wc_tens <= (r_wc_tens == 4'd9) ? 4'd0 : (r_wc_tens + 4'd1);
                end else begin
                    r_wc_ones <= r_wc_ones + 4'd1;
                end
            end
        end
    end

    // Frame snapshot taken on the 3->0 tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snap_val     <= 4'd0;
            r_snap_wc_ones <= 4'd0;
            r_snap_wc_tens <= 4'd0;
        end else if (w_frame_start) begin
            r_snap_val     <= value;
            r_snap_wc_ones <= r_wc_ones;
            r_snap_wc_tens <= r_wc_tens;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with REFRESH_DIV=4: expected slot
// outputs are queued before each stretch of stimulus and popped on each
// slot update. Slot updates land on posedges where cyc%4==0 (cyc counts
// posedges since reset release); the driven slot is (cyc/4)%4.
module tb_seg_scan_driver;

    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D3 = 7'b0110000;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D7 = 7'b1111000;
    localparam logic [6:0] D9 = 7'b0010000;
    localparam logic [6:0] BL = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] value = 4'd0;
    logic       finish = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } slot_t;

    slot_t exp_q[$];

    seg_scan_driver #(.REFRESH_DIV(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .value  (value),
        .finish (finish),
        .an     (an),
        .seg    (seg),
        .dp     (dp)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Advance at least one cycle, stopping at the given phase of the 16-cycle frame
    task automatic sync_phase(input int p);
        step();
        for (int n = 0; n < 16 && (cyc % 16) != p; n++) step();
    endtask

    task automatic push(input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_dp);
        slot_t e;
        e.an  = e_an;
        e.seg = e_seg;
        e.dp  = e_dp;
        exp_q.push_back(e);
    endtask

    task automatic check_now(input string tag, input logic [3:0] e_an,
                             input logic [6:0] e_seg, input logic e_dp);
        checks++;
        assert (an === e_an) else begin
            failures++;
            $error("FAIL %s_an observed=%b expected=%b", tag, an, e_an);
        end
        checks++;
        assert (seg === e_seg) else begin
            failures++;
            $error("FAIL %s_seg observed=%b expected=%b", tag, seg, e_seg);
        end
        checks++;
        assert (dp === e_dp) else begin
            failures++;
            $error("FAIL %s_dp observed=%b expected=%b", tag, dp, e_dp);
        end
    endtask

    task automatic check_slot(input string tag);
        slot_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s scoreboard_empty observed=0 expected=1", tag);
        end else begin
            e = exp_q.pop_front();
            check_now(tag, e.an, e.seg, e.dp);
        end
    endtask

    task automatic pulse_finish(input int n);
        for (int i = 0; i < n; i++) begin
            finish = 1'b1;
            step();
            finish = 1'b0;
            step();
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_now("reset_state", 4'b1111, BL, 1'b1);
        reset = 1'b0;
        cyc   = 0;

        // No tick yet: anodes stay off
        repeat (3) step();
        checks++;
        assert (an === 4'b1111) else begin
            failures++;
            $error("FAIL pre_tick_an observed=%b expected=%b", an, 4'b1111);
        end

        // First frame, value 0, wrap 00
        push(4'b1101, BL, 1'b1);
        push(4'b1011, D0, 1'b0);
        push(4'b0111, D0, 1'b1);
        push(4'b1110, D0, 1'b1);
        step();          check_slot("f1_idx1");
        sync_phase(8);   check_slot("f1_idx2");
        sync_phase(12);  check_slot("f1_idx3");
        sync_phase(0);   check_slot("f1_idx0");

        // value 13 after the snapshot: current frame still blank tens
        value = 4'd13;
        push(4'b1101, BL, 1'b1);
        sync_phase(4);   check_slot("v13_old_idx1");
        push(4'b1110, D3, 1'b1);
        push(4'b1101, D1, 1'b1);
        sync_phase(0);   check_slot("v13_idx0");
        sync_phase(4);   check_slot("v13_idx1");

        // value 5 snapped, then 9 just after the snapshot
        value = 4'd5;
        push(4'b1110, D5, 1'b1);
        sync_phase(0);   check_slot("v5_idx0");
        value = 4'd9;
        push(4'b1101, BL, 1'b1);
        push(4'b1110, D9, 1'b1);
        sync_phase(4);   check_slot("v9_idx1");
        sync_phase(0);   check_slot("v9_idx0");

        // finish held for 10 cycles counts once
        finish = 1'b1;
        repeat (10) step();
        finish = 1'b0;
        step();
        sync_phase(0);
        push(4'b1011, D1, 1'b0);
        push(4'b0111, D0, 1'b1);
        sync_phase(8);   check_slot("wc01_idx2");
        sync_phase(12);  check_slot("wc01_idx3");

        // 6 more pulses -> 07
        pulse_finish(6);
        sync_phase(0);
        push(4'b1011, D7, 1'b0);
        push(4'b0111, D0, 1'b1);
        sync_phase(8);   check_slot("wc07_idx2");
        sync_phase(12);  check_slot("wc07_idx3");

        // 92 more -> 99
        pulse_finish(92);
        sync_phase(0);
        push(4'b1011, D9, 1'b0);
        push(4'b0111, D9, 1'b1);
        sync_phase(8);   check_slot("wc99_idx2");
        sync_phase(12);  check_slot("wc99_idx3");

        // 100th pulse rolls to 00
        pulse_finish(1);
        sync_phase(0);
        push(4'b1011, D0, 1'b0);
        push(4'b0111, D0, 1'b1);
        sync_phase(8);   check_slot("wc00_idx2");
        sync_phase(12);  check_slot("wc00_idx3");

        // finish edge in the snapshot-tick cycle: shows one frame later
        sync_phase(15);
        finish = 1'b1;
        step();
        finish = 1'b0;
        push(4'b1011, D0, 1'b0);
        sync_phase(8);   check_slot("snapfin_cur_idx2");
        sync_phase(0);
        push(4'b1011, D1, 1'b0);
        sync_phase(8);   check_slot("snapfin_next_idx2");

        // Mid-slot reset at index2 blanks outputs without a clock edge
        step();
        #2 reset = 1'b1;
        #1 check_now("async_reset", 4'b1111, BL, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        sync_phase(0);
        push(4'b1011, D0, 1'b0);
        push(4'b0111, D0, 1'b1);
        sync_phase(8);   check_slot("post_rst_idx2");
        sync_phase(12);  check_slot("post_rst_idx3");

        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, SHALL set the clocks per digit slot (1 kHz slot rate at 50 MHz); legal range is 2 or greater.
REQ-002 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 value  input  4  SHALL carry the upstream counter value, 0..15, binary.
REQ-005 finish  input  1  SHALL carry the upstream wrap flag, a registered level that may stay high for several cycles.
REQ-006 an  output  4  SHALL be the digit anode enables, active-low, one-hot-low when driving.
REQ-007 seg  output  7  SHALL be the segment cathodes, active-low, bit order {g,f,e,d,c,b,a}.
REQ-008 dp  output  1  SHALL be the decimal-point cathode, active-low.

Function
REQ-009 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap; tick SHALL be high for exactly one cycle when the count equals REFRESH_DIV-1.
REQ-010 The scan index (2 bits) SHALL advance 0→1→2→3→0 on each tick and hold otherwise.
REQ-011 Digit map:
- index0 drives an=1110 and shows the value ones digit.
- index1 drives an=1101 and shows the value tens digit.
- index2 drives an=1011 and shows the wrap-count ones digit.
- index3 drives an=0111 and shows the wrap-count tens digit.
REQ-012 Value SHALL be converted to decimal (tens 0/1, ones 0..9); a tens digit of 0 at index1 SHALL be blanked (seg=1111111), and the anode SHALL still be driven.
REQ-013 Leading zeros of the wrap count SHALL NOT be blanked.
REQ-014 A rising edge of finish (finish=1, previous-cycle finish=0) SHALL increment a 2-digit BCD wrap count by exactly 1; a held-high finish SHALL count once.
REQ-015 The wrap count SHALL roll over from 99 to 00; no carry output.
REQ-016 Frame snapshot: on the tick that moves the index from 3 to 0, value and the wrap count SHALL be copied into display registers, so that all four digits of a frame show one coherent snapshot.
REQ-017 A finish edge in the same cycle as the snapshot tick SHALL appear in the next frame, not the current one.
REQ-018 an, seg and dp SHALL be registered, with one-cycle latency after the tick: they update in the cycle following the tick, from the new index.
REQ-019 dp SHALL be 0 (lit) only while index2 is driven, as the group separator; otherwise 1.
REQ-020 Segment encoding SHALL cover digits 0..9 plus a blank code; an out-of-range digit SHALL display blank.

Reset
REQ-021 Reset SHALL clear, asynchronously:
- the prescaler, scan index, finish history and wrap count (to 00);
- the display snapshot (to 0);
- the outputs: an=1111, seg=1111111, dp=1.
REQ-022 After reset deasserts, the first tick SHALL drive index1. The first snapshot SHALL occur on the fourth tick.
REQ-023 A finish edge coincident with reset SHALL NOT be counted. Reset asserted mid-frame SHALL blank the outputs immediately.

Structure
REQ-024 The segment codes (0..9, blank) and the anode patterns SHALL live in a shared package, seg_pkg, together with the REFRESH_DIV default.
REQ-025 A combinational sub-module, seg7_decoder (4-bit digit in, 7-bit active-low code out), SHALL be instantiated once, on the selected digit.

Verification (REFRESH_DIV=4)
REQ-026 Reset release, value=0, no finish:
- an stays 1111 until the first tick;
- the cycle-sequence of an is 1101, 1011, 0111, 1110;
- seg at index0 is 1000000 (0), index1 is blank, index2 and index3 are 1000000.
REQ-027 value=13, then a full frame:
- index1 shows 1111001 (1);
- index0 shows 0110000 (3).
REQ-028 Wrap count:
- finish held high for 10 cycles SHALL count 1;
- 100 separate pulses SHALL wrap the count to 00;
- 7 pulses SHALL show index2=1111000 (7) and index3=1000000 (0).
REQ-029 value changes 5→9 mid-frame, just after the snapshot: the displayed ones stay 5 until the next 3→0 tick, then show 9.
REQ-030 Reset asserted mid-frame at index2: an=1111, seg=1111111 and dp=1 asynchronously, and the wrap count reads 00 afterward.
REQ-031 A finish rising edge on the snapshot tick: the count increments, and the new value is displayed one frame later.
